clk_period_meter: RTL
=====================

# clk_period_meter

Measures a slow clock-like signal, such as a divided clock, in units of `sys_clk` cycles. It reports the period and high time of each cycle, flags a stalled input, and asserts lock once the period is stable. It is the receiving end of the clock-divider family and is used on-chip to check divider outputs and external reference clocks.

## Interface
Parameters:
- `CNT_W`, 16: width of the period and high-time counters and outputs.
- `TIMEOUT`, 1000: number of `sys_clk` cycles without a rising edge before `lost` asserts. Must satisfy 2 ≤ TIMEOUT < 2^CNT_W.
- `LOCK_CNT`, 4: number of consecutive equal-to-previous measurements required for `locked`. Range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `sys_clk`, input, 1: system clock.
- `sys_rst_n`, input, 1: asynchronous active-low reset.
- `in_clk`, input, 1: signal being measured, sampled by `sys_clk`.
- `period`, output, CNT_W: `sys_clk` cycles from one rising edge to the next, from the last completed measurement.
- `high_time`, output, CNT_W: cycles `in_clk` was high within that period, as sampled.
- `meas_valid`, output, 1: one-cycle pulse when `period` and `high_time` update.
- `locked`, output, 1: the period has been stable for LOCK_CNT consecutive comparisons.
- `lost`, output, 1: no rising edge seen for TIMEOUT cycles.

## Operation
- **Sampling:** `in_clk` passes through the sync stage (see Configuration) to give `in_s`. `in_d` is `in_s` delayed by one register. A rising edge is detected as `rise = in_s & ~in_d`.
- **State machine (2 states):**
  - SEEK (the reset state). Counters are idle.
    - On `rise`: go to MEASURE, set `cnt`=1 and `hi_cnt`=1.
    - No measurement is emitted on this first edge.
  - MEASURE, on a cycle with `rise`:
    - `period` ← `cnt`, `high_time` ← `hi_cnt`, `meas_valid` = 1.
    - Then `cnt` ← 1 and `hi_cnt` ← 1.
  - MEASURE, on a cycle without `rise`:
    - `cnt` ← `cnt`+1.
    - `hi_cnt` ← `hi_cnt`+1 only if `in_s` is 1.
  - MEASURE, when `cnt` reaches TIMEOUT and the current cycle has no `rise`:
    - Go to SEEK and set `lost` ← 1.
    - Clear `locked` and the match counter.
    - `period` and `high_time` hold their last values.
- **Counting rule:** the cycle containing the rise is cycle 1 of the new period. An `in_clk` toggling every 2 `sys_clk` cycles measures `period`=4, `high_time`=2.
- **Lost recovery:** `lost` clears on the next `rise`, in the same edge that moves SEEK to MEASURE.
- **Lock tracking:**
  - Each measurement is compared with the previous one; the stored previous value is cleared on entry to SEEK.
  - Equal: the match counter increments, saturating at LOCK_CNT.
  - Different, or the first measurement after SEEK: the match counter is set to 0.
  - `locked` = (match == LOCK_CNT), registered and updated in the same edge as `period`.
  - The earliest lock is therefore on the (LOCK_CNT+1)th measurement.
- **Arithmetic:** `cnt` never wraps, because the timeout fires first. `hi_cnt` ≤ `cnt` always holds. All counters are CNT_W bits and unsigned.
- **Reset values:**
  - Outputs: `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `lost`=0.
  - Internal: state SEEK, all sync flops 0.
- **Reset mid-operation:** every register clears immediately, without waiting for a clock. After release the block restarts in SEEK and needs a fresh first edge.
- **Minimum period:** the minimum measurable period is 2. A glitch shorter than one `sys_clk` cycle may be missed; this is acceptable.

## Timing
- Suppose an `in_clk` rising transition meets setup before `sys_clk` edge N.
  - With the sync macro: `rise` is true in the cycle after edge N+1, and the outputs update at edge N+2.
  - Without the macro: `rise` is true after edge N, and the outputs update at edge N+1.
- `meas_valid` is exactly 1 cycle wide and registered. No back-pressure exists; a consumer must capture the values in the pulse cycle or read the held outputs.
- `lost` asserts at the edge where `cnt` would reach TIMEOUT, i.e. TIMEOUT cycles after the last rise cycle.
- The sync-stage latency is constant, so it does not affect the measured values.

## Configuration
- Macro: `CLK_PERIOD_METER_SYNC_EN`.
- **Defined:** `in_s` comes from a two-flop synchronizer. Use this for an `in_clk` asynchronous to `sys_clk`.
- **Undefined:** `in_s` is a single register stage. Use this only when `in_clk` is generated in the `sys_clk` domain, such as a divider output; latency drops by one cycle.
- Measured values are identical in both builds.

## Test plan
- **Divide-by-4 input:** `in_clk` toggles every 2 cycles for 12 periods → every `meas_valid` shows `period`=4 and `high_time`=2. `locked` rises on the 5th `meas_valid` (LOCK_CNT=4), and `lost` stays 0.
- **Asymmetric duty:** 3 cycles high, 5 cycles low, repeated → `period`=8, `high_time`=3, and `meas_valid` pulses once every 8 cycles.
- **Stall:** lock on period 4, then hold `in_clk` at 0 → `lost`=1 and `locked`=0 exactly TIMEOUT cycles after the last rise. The next rise clears `lost`, and the following rise yields `period`=4.
- **Period change:** while locked at period 4, switch to period 6 → the first `meas_valid` with 6 drops `locked`, and it re-locks after 4 further equal measurements.
- **Reset mid-measure:** assert `sys_rst_n`=0 asynchronously between clock edges → all outputs read 0 before the next edge. After release, no `meas_valid` appears until the second rise.
- **Both builds:** run the divide-by-4 scenario with and without `CLK_PERIOD_METER_SYNC_EN` → identical values, with `meas_valid` one cycle later when the macro is defined.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock-like input in sys_clk cycles,
// with stall detection and lock tracking. Define CLK_PERIOD_METER_SYNC_EN for a 2-flop input synchronizer.
module clk_period_meter #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_clk,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned      MATCH_W      = 4;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_CNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE   = MATCH_W'(1);

  typedef enum logic {
    SEEK,
    MEASURE
  } state_t;

  state_t             state, state_nxt;
  logic               in_s, in_d, rise;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   hi_cnt, hi_cnt_nxt;
  logic [CNT_W-1:0]   period_nxt, high_time_nxt;
  logic [CNT_W-1:0]   prev_period, prev_period_nxt;
  logic               prev_vld, prev_vld_nxt;
  logic [MATCH_W-1:0] match, match_nxt;
  logic               meas_valid_nxt, locked_nxt, lost_nxt;

`ifdef CLK_PERIOD_METER_SYNC_EN
  logic in_meta;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_meta <= 1'b0;
      in_s    <= 1'b0;
    end else begin
      in_meta <= in_clk;
      in_s    <= in_meta;
    end
  end
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_s <= 1'b0;
    end else begin
      in_s <= in_clk;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_d <= 1'b0;
    end else begin
      in_d <= in_s;
    end
  end

  assign rise = in_s & ~in_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= SEEK;
      cnt         <= '0;
      hi_cnt      <= '0;
      period      <= '0;
      high_time   <= '0;
      prev_period <= '0;
      prev_vld    <= 1'b0;
      match       <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hi_cnt      <= hi_cnt_nxt;
      period      <= period_nxt;
      high_time   <= high_time_nxt;
      prev_period <= prev_period_nxt;
      prev_vld    <= prev_vld_nxt;
      match       <= match_nxt;
      meas_valid  <= meas_valid_nxt;
      locked      <= locked_nxt;
      lost        <= lost_nxt;
    end
  end

  // The rise cycle is cycle 1 of the new period, so counters restart at 1.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    hi_cnt_nxt      = hi_cnt;
    period_nxt      = period;
    high_time_nxt   = high_time;
    prev_period_nxt = prev_period;
    prev_vld_nxt    = prev_vld;
    match_nxt       = match;
    meas_valid_nxt  = 1'b0;
    locked_nxt      = locked;
    lost_nxt        = lost;

    case (state)
      SEEK: begin
        if (rise) begin
          state_nxt  = MEASURE;
          cnt_nxt    = CNT_ONE;
          hi_cnt_nxt = CNT_ONE;
          lost_nxt   = 1'b0;
        end
      end

      MEASURE: begin
        if (rise) begin
          period_nxt     = cnt;
          high_time_nxt  = hi_cnt;
          meas_valid_nxt = 1'b1;
          if (prev_vld && (cnt == prev_period)) begin
            match_nxt = (match == LOCK_TARGET) ? match : match + MATCH_ONE;
          end else begin
            match_nxt = '0;
          end
          locked_nxt      = (match_nxt == LOCK_TARGET);
          prev_period_nxt = cnt;
          prev_vld_nxt    = 1'b1;
          cnt_nxt         = CNT_ONE;
          hi_cnt_nxt      = CNT_ONE;
        end else if (cnt == TIMEOUT_LAST) begin
          // Stall: drop back to SEEK, forget lock history, keep last measurement.
          state_nxt       = SEEK;
          lost_nxt        = 1'b1;
          locked_nxt      = 1'b0;
          match_nxt       = '0;
          prev_vld_nxt    = 1'b0;
          prev_period_nxt = '0;
          cnt_nxt         = '0;
          hi_cnt_nxt      = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
          if (in_s) begin
            hi_cnt_nxt = hi_cnt + CNT_ONE;
          end
        end
      end

      default: begin
        state_nxt = SEEK;
      end
    endcase
  end

endmodule
